// File: rtl/preprocess_word_tracker_pkg.sv
// Shared definitions for the output-port-lookup preprocess stage.
// Holds the word-tracker state encodings and the Ethernet constants
// used by the optional VLAN detector.
package preprocess_pkg;

  // One-hot state encoding of the word-position tracker.
  typedef enum logic [2:0] {
    ST_FIRST    = 3'b001,  // next accepted beat is word 0
    ST_IN_HDR   = 3'b010,  // still issuing word strobes
    ST_WAIT_EOP = 3'b100   // all strobes issued, waiting for tlast
  } tracker_state_t;

  // Ethertype value that marks an 802.1Q tagged frame.
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;

  // Byte offset of the ethertype field inside the first beat.
  localparam int ETHERTYPE_BYTE_OFFSET = 12;

  // Bit index of the MSB of a byte in a bus whose byte 0 sits at the MSBs.
  function automatic int byte_msb(input int bus_width, input int byte_off);
    return bus_width - 1 - 8 * byte_off;
  endfunction

endpackage

// File: rtl/preprocess_word_tracker_beat_counter.sv
// Saturating beat counter: clear wins over increment, and once the
// counter reaches all-ones it stays there until cleared.
module beat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic sat;
  assign sat = &cnt;

  // Clear on packet end, otherwise count accepted beats up to saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/preprocess_word_tracker.sv
// Packet word-position tracker. Passively taps an AXI-Stream beat flow
// and emits one-hot word strobes for the first C_NUM_STROBES beats of
// every packet, plus sop/eop, a registered runt pulse and (optionally)
// a registered VLAN-present flag.
// Optional feature macro: PREPROCESS_VLAN_EN enables the ethertype compare
// that drives vlan_present; without it vlan_present is tied low.
module preprocess_word_tracker
  import preprocess_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_NUM_STROBES       = 4,
  parameter int C_BEAT_CNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] tdata,
  input  logic                           tvalid,
  input  logic                           tready,
  input  logic                           tlast,
  output logic [C_NUM_STROBES-1:0]       word_strobe,
  output logic [C_BEAT_CNT_WIDTH-1:0]    beat_idx,
  output logic                           sop,
  output logic                           eop,
  output logic                           runt,
  output logic                           vlan_present
);

  // Beat index at which the final strobe fires.
  localparam logic [C_BEAT_CNT_WIDTH-1:0] LAST_STROBE =
    C_BEAT_CNT_WIDTH'(C_NUM_STROBES - 1);

  tracker_state_t              state;
  logic                        accept;
  logic [C_BEAT_CNT_WIDTH-1:0] beat_cnt;

  // Only the ethertype bytes are ever looked at; the rest of the beat is
  // passed through untouched downstream, so fold it away explicitly.
  logic unused_tdata;
  assign unused_tdata = ^tdata;

  // A beat counts only when the handshake completes; reset masks
  // everything so no output reacts while the block is being cleared.
  assign accept = tvalid && tready && !reset;

  beat_counter #(
    .WIDTH (C_BEAT_CNT_WIDTH)
  ) u_beat_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (accept && tlast),
    .inc   (accept && !tlast),
    .cnt   (beat_cnt)
  );

  // One-hot word strobes, one comparator per word.
  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_STROBES; gi++) begin : g_strobe
      assign word_strobe[gi] = accept &&
                               (beat_cnt == C_BEAT_CNT_WIDTH'(gi));
    end
  endgenerate

  assign sop      = accept && (state == ST_FIRST);
  assign eop      = accept && tlast;
  assign beat_idx = reset ? '0 : beat_cnt;

  // Packet-position FSM; runt is registered alongside it and flags a
  // packet whose tlast arrived before the final strobe was issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FIRST;
      runt  <= 1'b0;
    end else begin
      runt <= accept && tlast && (beat_cnt < LAST_STROBE);
      if (accept) begin
        case (state)
          ST_FIRST: begin
            if (tlast)                  state <= ST_FIRST;
            else if (C_NUM_STROBES > 1) state <= ST_IN_HDR;
            else                        state <= ST_WAIT_EOP;
          end
          ST_IN_HDR: begin
            if (tlast)                        state <= ST_FIRST;
            else if (beat_cnt == LAST_STROBE) state <= ST_WAIT_EOP;
          end
          ST_WAIT_EOP: begin
            if (tlast) state <= ST_FIRST;
          end
          default: state <= ST_FIRST;
        endcase
      end
    end
  end

`ifdef PREPROCESS_VLAN_EN
  localparam int ETH_MSB = byte_msb(C_S_AXIS_DATA_WIDTH, ETHERTYPE_BYTE_OFFSET);

  // Sample the ethertype on word 0 and hold the result for the packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      vlan_present <= 1'b0;
    end else if (sop) begin
      vlan_present <= (tdata[ETH_MSB -: 16] == ETHERTYPE_VLAN);
    end
  end
`else
  assign vlan_present = 1'b0;
`endif

endmodule

// File: tb/tb_preprocess_word_tracker.sv
// Directed, table-driven bench for preprocess_word_tracker (N=4, W=256).
// Inputs change on the falling edge; outputs are sampled 1ns later, so
// combinational outputs reflect the current beat and runt/vlan_present
// reflect the beat of the previous cycle.
module tb_preprocess_word_tracker;

  localparam int DW = 256;
  localparam int NS = 4;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast;
  logic [NS-1:0] word_strobe;
  logic [BW-1:0] beat_idx;
  logic          sop, eop, runt, vlan_present;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  preprocess_word_tracker #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_NUM_STROBES       (NS),
    .C_BEAT_CNT_WIDTH    (BW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tdata        (tdata),
    .tvalid       (tvalid),
    .tready       (tready),
    .tlast        (tlast),
    .word_strobe  (word_strobe),
    .beat_idx     (beat_idx),
    .sop          (sop),
    .eop          (eop),
    .runt         (runt),
    .vlan_present (vlan_present)
  );

  typedef struct {
    logic          rst, v, r, l;
    logic [NS-1:0] strobe;
    logic          sop, eop, runt;
    logic [BW-1:0] idx;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic v, input logic r,
                              input logic l, input logic [NS-1:0] strobe,
                              input logic s, input logic e, input logic rn,
                              input logic [BW-1:0] idx);
    vec_t t;
    t.rst = rst; t.v = v; t.r = r; t.l = l;
    t.strobe = strobe; t.sop = s; t.eop = e; t.runt = rn; t.idx = idx;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic r,
                       input logic l);
    @(negedge clk);
    reset = rst; tvalid = v; tready = r; tlast = l;
    #1;
  endtask

  string nm;

  initial begin
    reset = 1'b1; tdata = '0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    repeat (2) @(posedge clk);

    //   rst v r l  strobe  sop eop runt idx
    // reset holds everything low even with a valid handshake
    add(1, 1, 1, 1, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
    // 6-beat packet, no runt
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0010, 0, 0, 0, 1);
    add(0, 1, 1, 0, 4'b0100, 0, 0, 0, 2);
    add(0, 1, 1, 0, 4'b1000, 0, 0, 0, 3);
    add(0, 1, 1, 0, 4'b0000, 0, 0, 0, 4);
    add(0, 1, 1, 1, 4'b0000, 0, 1, 0, 5);
    add(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
    // 2-beat packet: runt the cycle after eop
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0010, 0, 1, 0, 1);
    add(0, 0, 1, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
    // 1-beat packet
    add(0, 1, 1, 1, 4'b0001, 1, 1, 0, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
    // stall on beat 2; tlast during stall is not accepted
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0010, 0, 0, 0, 1);
    add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 2);
    add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 2);
    add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 2);
    add(0, 1, 1, 0, 4'b0100, 0, 0, 0, 2);
    add(0, 1, 1, 1, 4'b1000, 0, 1, 0, 3);
    add(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
    // reset after beat 1, then a fresh 2-beat packet
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0010, 0, 0, 0, 1);
    add(1, 1, 1, 1, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0001, 1, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0010, 0, 1, 0, 1);
    add(0, 0, 1, 0, 4'b0000, 0, 0, 1, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].v, vecs[k].r, vecs[k].l);
      nm = $sformatf("v%0d", k);
      chk({nm, ".strobe"}, 32'(word_strobe), 32'(vecs[k].strobe));
      chk({nm, ".sop"},    32'(sop),         32'(vecs[k].sop));
      chk({nm, ".eop"},    32'(eop),         32'(vecs[k].eop));
      chk({nm, ".runt"},   32'(runt),        32'(vecs[k].runt));
      chk({nm, ".idx"},    32'(beat_idx),    32'(vecs[k].idx));
      chk({nm, ".vlan"},   32'(vlan_present), 32'd0);
    end

    // Long packet: beat index saturates at 255 and never wraps.
    for (int i = 0; i < 300; i++) drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("sat.idx", 32'(beat_idx), 32'd255);
    chk("sat.strobe", 32'(word_strobe), 32'd0);
    chk("sat.sop", 32'(sop), 32'd0);
    drive(0, 1, 1, 1);
    chk("sat.eop", 32'(eop), 32'd1);
    chk("sat.idx_last", 32'(beat_idx), 32'd255);
    drive(0, 0, 1, 0);
    chk("sat.clear", 32'(beat_idx), 32'd0);
    chk("sat.runt", 32'(runt), 32'd0);

    // VLAN detection on word 0.
    tdata = '0;
    tdata[DW-97 -: 16] = 16'h8100;
    drive(0, 1, 1, 1);
    chk("vlan.sop", 32'(sop), 32'd1);
    tdata = '0;
    drive(0, 0, 1, 0);
`ifdef PREPROCESS_VLAN_EN
    chk("vlan.set", 32'(vlan_present), 32'd1);
`else
    chk("vlan.tied", 32'(vlan_present), 32'd0);
`endif
    tdata[DW-97 -: 16] = 16'h0800;
    drive(0, 1, 1, 0);
`ifdef PREPROCESS_VLAN_EN
    chk("vlan.hold", 32'(vlan_present), 32'd1);
`else
    chk("vlan.hold", 32'(vlan_present), 32'd0);
`endif
    tdata = '0;
    drive(0, 1, 1, 1);
    chk("vlan.clr", 32'(vlan_present), 32'd0);
    drive(0, 0, 1, 0);
    chk("vlan.clr2", 32'(vlan_present), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/preprocess_word_tracker.md
# preprocess_word_tracker

Parametrised packet word-position tracker for the router output-port-lookup preprocess stage. It passively taps the AXI-Stream beat flow and produces one-hot, beat-aligned strobes for the first `C_NUM_STROBES` words of every packet, so the parsers know which word they are seeing. It also reports start/end of packet, a runt indication and, optionally, VLAN presence. It generalises the fixed two-word (IP_DST_HI/LO) control to arbitrary bus width and strobe count, and adds handshake qualification.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 256, tdata width in bits; must be a multiple of 64 and at least 128.
- `C_NUM_STROBES`, 4, number of word strobes (words 0..N-1); range 1..16.
- `C_BEAT_CNT_WIDTH`, 8, width of the beat index counter; must satisfy 2^W > C_NUM_STROBES.

Ports:
- `clk`, in, 1, clock.
- `reset`, in, 1, synchronous, active-high.
- `tdata`, in, C_S_AXIS_DATA_WIDTH, stream data; byte 0 is at the MSBs.
- `tvalid`, in, 1, beat valid.
- `tready`, in, 1, downstream ready; the block only observes it and never drives it.
- `tlast`, in, 1, last beat of the packet.
- `word_strobe`, out, C_NUM_STROBES, one-hot; bit i is high during accepted beat i.
- `beat_idx`, out, C_BEAT_CNT_WIDTH, index of the current beat; saturates.
- `sop`, out, 1, high during the first accepted beat.
- `eop`, out, 1, high during the accepted tlast beat.
- `runt`, out, 1, registered one-cycle pulse.
- `vlan_present`, out, 1, registered flag (VLAN build only).

## Operation
- A beat is accepted when `tvalid && tready`. No output ever reacts to an unaccepted beat.
- The state machine has three states:
  - **FIRST**: the next accepted beat is word 0.
  - **IN_HDR**: `beat_cnt` < C_NUM_STROBES.
  - **WAIT_EOP**: all strobes have been issued.
- Transitions:
  - FIRST: on accept, go to FIRST if `tlast`. Otherwise go to IN_HDR if C_NUM_STROBES > 1, else WAIT_EOP.
  - IN_HDR: on accept with `tlast`, go to FIRST. On accept when `beat_cnt` == C_NUM_STROBES-1, go to WAIT_EOP.
  - WAIT_EOP: on accept with `tlast`, go to FIRST.
- `beat_cnt` is 0 in FIRST and increments on every accepted non-last beat. It saturates at 2^W-1 and never wraps. It clears to 0 on an accepted `tlast` beat.
- Combinational outputs are gated by accept:
  - `word_strobe[i]` = accept && (`beat_cnt` == i) && (i < C_NUM_STROBES).
  - `sop` = accept && state==FIRST.
  - `eop` = accept && `tlast`.
  - `beat_idx` = `beat_cnt`, ungated.
- `runt` pulses for one cycle after an accepted `tlast` beat whose `beat_cnt` is < C_NUM_STROBES-1, i.e. the packet ended before the last strobe.
- A single-beat packet asserts `sop`, `eop` and `word_strobe[0]` together. It also pulses `runt` if C_NUM_STROBES > 1.

## Timing
- Strobes, `sop` and `eop` have zero latency: they are valid in the same cycle as the accepted beat.
- `runt` and `vlan_present` update one cycle after the qualifying beat.
- Reset values: state=FIRST, `beat_cnt`=0, `runt`=0, `vlan_present`=0. All combinational outputs are 0 while `reset` is high.
- Reset mid-packet abandons the packet. The next accepted beat after reset is treated as word 0 and no `runt` is emitted.
- When `tvalid` is high and `tready` is low, all state and outputs hold and strobes stay low.

## Configuration
- `PREPROCESS_VLAN_EN` defined:
  - On `sop`, `vlan_present` is registered as (ethertype bytes 12–13 == 16'h8100). These are `tdata[W-97:W-112]`.
  - The flag holds until the next `sop`.
- Undefined: `vlan_present` is tied to 0 and the compare logic is absent.

## Structure
- The shared package `preprocess_pkg` holds:
  - state encodings FIRST=3'b001, IN_HDR=3'b010, WAIT_EOP=3'b100;
  - `ETHERTYPE_VLAN`=16'h8100;
  - the byte offset 12 of the ethertype.
- Sub-module `beat_counter` (saturating, with clear and increment enable) is natural. It is instantiated once.

## Test plan
- N=4, W=256. Send a 6-beat packet with `tready` always 1. Expected:
  - `word_strobe` = 0001, 0010, 0100, 1000, 0000, 0000;
  - `sop` on beat 0 and `eop` on beat 5;
  - no `runt`.
- Send a 2-beat packet. Expected: strobes 0001 then 0010, `eop` on beat 1, and `runt` pulses the cycle after.
- Send a 1-beat packet. Expected: `sop`, `eop` and strobe 0001 in the same cycle, and `runt`=1 next cycle.
- Drop `tready` for 3 cycles on beat 2. Expected: strobes low during the stall, then 0100 on accept, and `beat_idx` held at 2 throughout.
- Assert `reset` after beat 1 of a packet, then send a new packet. Expected: its first beat gives `sop`=1 and strobe 0001, with no `runt`.
- With `PREPROCESS_VLAN_EN`, send word 0 with ethertype 8100. Expected: `vlan_present`=1 from the next cycle, and 0 after the next packet with ethertype 0800.
